// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH   = 1024;
  localparam int DEFAULT_LATENCY = 2;

  // Y86 instruction codes that touch data memory, for requester-side decode.
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  function automatic logic is_mem_write(input logic [3:0] icode);
    return (icode == ICODE_RMMOVQ) || (icode == ICODE_CALL) || (icode == ICODE_PUSHQ);
  endfunction

  function automatic logic is_mem_read(input logic [3:0] icode);
    return (icode == ICODE_MRMOVQ) || (icode == ICODE_RET) || (icode == ICODE_POPQ);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x 64, registered read. Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  // Write on we; read returns the pre-write word one edge later.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one read or write per valid/ready transaction,
// programmable access latency, out-of-range addresses flagged as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  // state | meaning
  // IDLE  | ready for a request, outputs cleared
  // WAIT  | latency countdown; access performed when cnt reaches 0
  // RESP  | response held until resp_ready

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] DEPTH_W  = 64'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        lat_write, lat_write_nxt;
  logic [63:0] lat_addr, lat_addr_nxt;
  logic [63:0] lat_wdata, lat_wdata_nxt;
  logic        resp_valid_nxt;
  logic [63:0] resp_rdata_nxt;
  logic        resp_err_nxt;

  logic          in_range;
  logic          commit;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [63:0]   ram_rdata;

  // Full-width compare so huge addresses never alias into the array.
  assign in_range  = (lat_addr < DEPTH_W);
  assign commit    = (state == WAIT) && (cnt == 4'd0);
  assign ram_we    = commit && lat_write && in_range;
  // In IDLE the RAM reads the incoming address so data is ready even for LATENCY=1.
  assign ram_addr  = (state == IDLE) ? req_addr[AW-1:0] : lat_addr[AW-1:0];
  assign req_ready = (state == IDLE);

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (lat_wdata),
    .rdata (ram_rdata)
  );

  // State, counter, latched request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 64'd0;
      lat_wdata  <= 64'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      lat_write  <= lat_write_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_wdata  <= lat_wdata_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
      resp_err   <= resp_err_nxt;
    end
  end

  // Next-state, countdown, access result and response handshake.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    lat_write_nxt  = lat_write;
    lat_addr_nxt   = lat_addr;
    lat_wdata_nxt  = lat_wdata;
    resp_valid_nxt = resp_valid;
    resp_rdata_nxt = resp_rdata;
    resp_err_nxt   = resp_err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          lat_write_nxt = req_write;
          lat_addr_nxt  = req_addr;
          lat_wdata_nxt = req_wdata;
          cnt_nxt       = CNT_INIT;
          state_nxt     = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = !in_range;
          resp_rdata_nxt = (in_range && !lat_write) ? ram_rdata : 64'd0;
          state_nxt      = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_nxt = 1'b0;
          resp_rdata_nxt = 64'd0;
          resp_err_nxt   = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
